sdram_refresh_scheduler: RTL and testbench
==========================================

SDRAM_REFRESH_SCHEDULER -- requirements
Module: sdram_refresh_scheduler

Interface
REQ-001 SHALL have parameter T_REFRESH_INTERVAL_CYCLES, default 782, meaning HCLK cycles per refresh credit; legal range >= 2.
REQ-002 SHALL have parameter MAX_PENDING, default 8, meaning maximum postponed refreshes owed; legal range >= 1.
REQ-003 SHALL have parameter URGENT_THRESHOLD, default 6, meaning the pending count at which urgency asserts; legal range 1..MAX_PENDING.
REQ-004 SHALL have parameter INIT_REFRESHES, default 2, meaning back-to-back refreshes issued after the SDRAM becomes ready; legal range 1..MAX_PENDING.
REQ-005 SHALL define PW = clog2(MAX_PENDING+1) and TW = clog2(T_REFRESH_INTERVAL_CYCLES) as local widths.
REQ-006 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-007 HRESETn  input  1  asynchronous, active-low reset.
REQ-008 sdram_ready_i  input  1  SDRAM power-up/init sequence complete.
REQ-009 refresh_ack_i  input  1  one-cycle pulse: command engine issued one AUTO REFRESH this cycle.
REQ-010 refresh_req_o  output  1  level: at least one refresh owed.
REQ-011 refresh_urgent_o  output  1  level: owed refreshes >= URGENT_THRESHOLD; engine must preempt traffic.
REQ-012 pending_cnt_o  output  PW  current owed-refresh count.
REQ-013 overflow_err_o  output  1  sticky: a credit was lost at saturation.

Function
REQ-014 SHALL implement a three-state FSM: OFF, INIT, RUN.
REQ-015 OFF: timer held at T_REFRESH_INTERVAL_CYCLES-1; pending held at 0; on a cycle with sdram_ready_i=1, go to INIT and load pending with INIT_REFRESHES.
REQ-016 INIT: timer held; each refresh_ack_i decrements pending; the edge that takes pending to 0 moves to RUN and loads timer with T_REFRESH_INTERVAL_CYCLES-1.
REQ-017 RUN: timer decrements by 1 per cycle; an edge sampling timer==0 is a tick: timer reloads to T_REFRESH_INTERVAL_CYCLES-1 and pending increments.
REQ-018 First RUN tick SHALL occur so pending becomes 1 exactly T_REFRESH_INTERVAL_CYCLES edges after the INIT-to-RUN edge; ticks repeat with period T_REFRESH_INTERVAL_CYCLES, independent of acks.
REQ-019 RUN: refresh_ack_i with pending>0 and no tick SHALL decrement pending by 1.
REQ-020 Tick and ack in the same cycle SHALL leave pending unchanged, including at pending==MAX_PENDING; overflow_err_o is not set.
REQ-021 Tick with pending==MAX_PENDING and no ack SHALL keep pending at MAX_PENDING and set overflow_err_o.
REQ-022 refresh_ack_i with pending==0 SHALL be ignored in all states; pending never wraps below 0.
REQ-023 Any cycle with sdram_ready_i=0 in INIT or RUN SHALL return to OFF next edge, clear pending, and reload timer; overflow_err_o is retained.
REQ-024 refresh_req_o SHALL equal (pending!=0); refresh_urgent_o SHALL equal (pending>=URGENT_THRESHOLD); both are decoded from registers with no input-to-output combinational path.
REQ-025 pending_cnt_o SHALL be the pending register directly.
REQ-026 overflow_err_o SHALL clear only on HRESETn.

Reset
REQ-027 HRESETn low SHALL asynchronously force OFF, pending=0, timer=T_REFRESH_INTERVAL_CYCLES-1, and overflow_err_o=0, so all outputs read 0.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL discard owed credits; after release the block behaves as from power-up.

Verification (T_REFRESH_INTERVAL_CYCLES=16, MAX_PENDING=8, URGENT_THRESHOLD=6, INIT_REFRESHES=2)
REQ-029 Init sequence: reset, then sdram_ready_i=1 -> next edge pending=2 and req=1; two acks bring pending to 0 and enter RUN; pending becomes 1 exactly 16 edges later.
REQ-030 Steady state: ack one cycle after each req rise -> req is a 1-cycle level every 16 cycles; pending never exceeds 1; urgent=0.
REQ-031 Postponement: no acks for 6x16 cycles in RUN -> pending counts 1..6 and urgent rises on the edge pending reaches 6; after 2 acks, pending=4 and urgent=0.
REQ-032 Saturation: no acks for 9x16 cycles -> pending stays 8 and overflow_err_o=1 after the 9th tick; an ack coincident with the next tick leaves pending=8; err stays 1 until reset.
REQ-033 Boundaries: ack at pending=0 leaves pending=0 with no wrap; sdram_ready_i dropped at pending=5 -> OFF, pending=0, req=0, err unchanged; reassert -> INIT with pending=2.
REQ-034 Async reset asserted between clock edges mid-RUN -> all outputs 0 immediately, without waiting for an HCLK edge.

Source files
------------

// File: rtl/sdram_refresh_scheduler.sv
// rtl/sdram_refresh_scheduler.sv - SDRAM auto-refresh credit scheduler
// Accrues one refresh credit per interval, tracks postponed refreshes and flags urgency/overflow.
module sdram_refresh_scheduler #(
  parameter int unsigned T_REFRESH_INTERVAL_CYCLES = 782,
  parameter int unsigned MAX_PENDING               = 8,
  parameter int unsigned URGENT_THRESHOLD          = 6,
  parameter int unsigned INIT_REFRESHES            = 2,
  localparam int PW = $clog2(MAX_PENDING + 1),
  localparam int TW = $clog2(T_REFRESH_INTERVAL_CYCLES)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          sdram_ready_i,
  input  logic          refresh_ack_i,
  output logic          refresh_req_o,
  output logic          refresh_urgent_o,
  output logic [PW-1:0] pending_cnt_o,
  output logic          overflow_err_o
);

  typedef enum logic [1:0] {ST_OFF, ST_INIT, ST_RUN} state_e;

  localparam logic [TW-1:0] TIMER_RELOAD = TW'(T_REFRESH_INTERVAL_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX     = PW'(MAX_PENDING);
  localparam logic [PW-1:0] PEND_URGENT  = PW'(URGENT_THRESHOLD);
  localparam logic [PW-1:0] PEND_INIT    = PW'(INIT_REFRESHES);

  state_e        state_q, state_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;

  logic tick;
  logic ack_ok;

  assign tick   = (state_q == ST_RUN) && (timer_q == '0);
  assign ack_ok = refresh_ack_i && (pending_q != '0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_OFF;
      pending_q <= '0;
      timer_q   <= TIMER_RELOAD;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:  if (sdram_ready_i) state_d = ST_INIT;
      ST_INIT: begin
        if (!sdram_ready_i) state_d = ST_OFF;
        else if (ack_ok && (pending_q == PW'(1))) state_d = ST_RUN;
      end
      ST_RUN:  if (!sdram_ready_i) state_d = ST_OFF;
      default: state_d = ST_OFF;
    endcase
  end

  // A tick and an ack in the same cycle cancel, so saturation only overflows on an unserviced tick.
  always_comb begin
    pending_d = pending_q;
    timer_d   = TIMER_RELOAD;
    err_d     = err_q;
    case (state_q)
      ST_INIT: begin
        if (!sdram_ready_i) pending_d = '0;
        else if (ack_ok)    pending_d = pending_q - PW'(1);
      end
      ST_RUN: begin
        if (!sdram_ready_i) begin
          pending_d = '0;
        end else begin
          timer_d = tick ? TIMER_RELOAD : timer_q - TW'(1);
          if (tick && !ack_ok) begin
            if (pending_q == PEND_MAX) err_d = 1'b1;
            else                       pending_d = pending_q + PW'(1);
          end else if (!tick && ack_ok) begin
            pending_d = pending_q - PW'(1);
          end
        end
      end
      default: pending_d = sdram_ready_i ? PEND_INIT : '0;
    endcase
  end

  always_comb begin
    refresh_req_o    = (pending_q != '0);
    refresh_urgent_o = (pending_q >= PEND_URGENT);
    pending_cnt_o    = pending_q;
    overflow_err_o   = err_q;
  end

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// tb/tb_sdram_refresh_scheduler.sv - scoreboard bench for sdram_refresh_scheduler
// Randomized and directed stimulus checked against an event-time reference model.
module tb_sdram_refresh_scheduler;
  localparam int T     = 16;
  localparam int MAXP  = 8;
  localparam int URG   = 6;
  localparam int INITR = 2;
  localparam int PW    = $clog2(MAXP + 1);

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          sdram_ready_i;
  logic          refresh_ack_i;
  logic          refresh_req_o;
  logic          refresh_urgent_o;
  logic [PW-1:0] pending_cnt_o;
  logic          overflow_err_o;

  sdram_refresh_scheduler #(
    .T_REFRESH_INTERVAL_CYCLES(T),
    .MAX_PENDING(MAXP),
    .URGENT_THRESHOLD(URG),
    .INIT_REFRESHES(INITR)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .sdram_ready_i(sdram_ready_i),
    .refresh_ack_i(refresh_ack_i),
    .refresh_req_o(refresh_req_o),
    .refresh_urgent_o(refresh_urgent_o),
    .pending_cnt_o(pending_cnt_o),
    .overflow_err_o(overflow_err_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int pend;
    bit req;
    bit urg;
    bit err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: mode 0=off, 1=init, 2=run; credits arrive at absolute edge indices.
  int m_mode = 0;
  int m_pend = 0;
  bit m_err  = 1'b0;
  int cyc    = 0;
  int next_tick = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", name, got, exp, cyc, $time);
  endtask

  function automatic void model_edge(input bit rst_n, input bit rdy, input bit ak);
    bit is_tick;
    bit ak_ok;
    if (!rst_n) begin
      m_mode = 0; m_pend = 0; m_err = 1'b0;
    end else if (m_mode == 0) begin
      if (rdy) begin m_mode = 1; m_pend = INITR; end
    end else if (!rdy) begin
      m_mode = 0; m_pend = 0;
    end else if (m_mode == 1) begin
      if (ak && m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin m_mode = 2; next_tick = cyc + T; end
      end
    end else begin
      is_tick = (cyc == next_tick);
      if (is_tick) next_tick += T;
      ak_ok = ak && (m_pend > 0);
      if (is_tick && !ak_ok) begin
        if (m_pend == MAXP) m_err = 1'b1;
        else m_pend++;
      end else if (!is_tick && ak_ok) begin
        m_pend--;
      end
    end
    cyc++;
  endfunction

  function automatic exp_t cur_exp();
    exp_t e;
    e.pend = m_pend;
    e.req  = (m_pend != 0);
    e.urg  = (m_pend >= URG);
    e.err  = m_err;
    return e;
  endfunction

  // Inputs are applied at posedge+1; the expectation for the edge is queued right at that edge.
  task automatic cycle(input bit rst_n, input bit rdy, input bit ak);
    HRESETn = rst_n; sdram_ready_i = rdy; refresh_ack_i = ak;
    model_edge(rst_n, rdy, ak);
    @(posedge HCLK);
    sb_q.push_back(cur_exp());
    #1;
  endtask

  task automatic run_until_pend(input string name, input int target, input bit ak, input int limit);
    int k = 0;
    while (m_pend != target && k < limit) begin
      cycle(1'b1, 1'b1, ak);
      k++;
    end
    check(name, m_pend, target);
  endtask

  always @(negedge HCLK) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("pending_cnt", int'(pending_cnt_o), e.pend);
      check("refresh_req", int'(refresh_req_o), int'(e.req));
      check("refresh_urgent", int'(refresh_urgent_o), int'(e.urg));
      check("overflow_err", int'(overflow_err_o), int'(e.err));
    end
  end

  initial begin
    HRESETn = 1'b0; sdram_ready_i = 1'b0; refresh_ack_i = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 1'b0, 1'b0);

    // Init sequence, then steady state servicing each request one cycle after it rises
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    check("entered_run", m_mode, 2);
    repeat (5 * T) cycle(1'b1, 1'b1, (m_pend > 0));
    run_until_pend("drain_before_postpone", 0, 1'b1, 4);

    // Postponement to urgency, partial service, then saturation
    repeat (6 * T) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    repeat (4 * T) cycle(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < T && cyc != next_tick; k++) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    repeat (3) cycle(1'b1, 1'b1, 1'b0);

    // Drain, acks at zero, then drop ready at pending 5 and re-init
    run_until_pend("drain_after_sat", 0, 1'b1, 20);
    repeat (3) cycle(1'b1, 1'b1, 1'b1);
    run_until_pend("reach_five", 5, 1'b0, 8 * T);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    repeat (4) cycle(1'b1, 1'b1, 1'b1);

    for (int k = 0; k < 800; k++)
      cycle(1'b1, ($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0));

    for (int k = 0; k < 10 && m_mode != 2; k++) cycle(1'b1, 1'b1, 1'b1);
    run_until_pend("reach_three", 3, 1'b0, 4 * T);

    // Asynchronous reset between edges must clear outputs immediately
    @(negedge HCLK);
    #1;
    HRESETn = 1'b0;
    #1;
    check("async_pending", int'(pending_cnt_o), 0);
    check("async_req", int'(refresh_req_o), 0);
    check("async_urgent", int'(refresh_urgent_o), 0);
    check("async_err", int'(overflow_err_o), 0);
    model_edge(1'b0, 1'b1, 1'b0);
    @(posedge HCLK);
    sb_q.push_back(cur_exp());
    #1;
    repeat (2) cycle(1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    repeat (2) cycle(1'b1, 1'b1, 1'b1);
    repeat (T + 2) cycle(1'b1, 1'b1, 1'b0);

    @(negedge HCLK);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
